// File: rtl/s_term_cfg_loopback.sv
// s_term_cfg_loopback: south terminal tile with configurable loopback.
// Each N_BEG channel is driven from one of four S_END buses. The channel is
// either a combinational path or a one-cycle registered path. Configuration
// frames are captured into a shadow store and copied to the active store in
// one step after the strobe burst ends.
//
// Ports:
//   UserCLK       tile clock, rising edge
//   resetn        asynchronous active-low reset
//   S_END         four source buses; bus b = S_END[b*WIRES +: WIRES]
//   N_BEG         loopback outputs, one per channel
//   FrameData     configuration word
//   FrameStrobe   per-frame write strobes (level)
//   FrameStrobe_O strobes forwarded up the column, STROBE_PIPE cycles late
//   UserCLKo      forwarded clock
//   cfg_busy      high while a burst is open or a commit is pending
module s_term_cfg_loopback #(
  parameter int unsigned WIRES           = 16,
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned STROBE_PIPE     = 1
) (
  input  logic                       UserCLK,
  input  logic                       resetn,
  input  logic [4*WIRES-1:0]         S_END,
  output logic [WIRES-1:0]           N_BEG,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
  output logic                       UserCLKo,
  output logic                       cfg_busy
);

  localparam int unsigned NCB = 3 * WIRES;
  localparam int unsigned NF  = (NCB + FrameBitsPerRow - 1) / FrameBitsPerRow;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [NCB-1:0]   shadow_q, shadow_d;
  logic [NCB-1:0]   active_q, active_d;
  logic [WIRES-1:0] chan_q, chan_d;
  logic [WIRES-1:0] src_act;
  logic [WIRES-1:0] reg_en;
  logic             act;

  // Per-channel bus selection using the sel fields of cfg.
  function automatic logic [WIRES-1:0] route(input logic [NCB-1:0]     cfg,
                                             input logic [4*WIRES-1:0] buses);
    logic [WIRES-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < WIRES; i++) begin
      case (cfg[3*i +: 2])
        2'd0:    r[i] = buses[i];
        2'd1:    r[i] = buses[WIRES + i];
        2'd2:    r[i] = buses[2*WIRES + i];
        default: r[i] = buses[3*WIRES + i];
      endcase
    end
    return r;
  endfunction

  assign act = |FrameStrobe[NF-1:0];

  // Config bit n lives in frame n / FrameBitsPerRow, so the flat vector
  // is the frames concatenated; bits past NCB are never stored.
  always_comb begin
    shadow_d = shadow_q;
    for (int unsigned n = 0; n < NCB; n++) begin
      if (FrameStrobe[n / FrameBitsPerRow]) shadow_d[n] = FrameData[n % FrameBitsPerRow];
    end
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    case (state_q)
      IDLE:    if (act) state_d = WRITE;
      WRITE:   if (!act) state_d = COMMIT;
      COMMIT: begin
        // Commit takes the pre-edge shadow even if a new burst starts now.
        active_d = shadow_q;
        state_d  = act ? WRITE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The channel register samples through the select that will be active
  // after this edge, so a sel change on commit never shows the old bus.
  always_comb begin
    src_act = route(active_q, S_END);
    chan_d  = route(active_d, S_END);
    for (int unsigned i = 0; i < WIRES; i++) reg_en[i] = active_q[3*i + 2];
    N_BEG = (reg_en & chan_q) | (~reg_en & src_act);
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      active_q <= '0;
      chan_q   <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      chan_q   <= chan_d;
    end
  end

  assign cfg_busy = (state_q != IDLE);
  assign UserCLKo = UserCLK;

  if (STROBE_PIPE == 0) begin : g_nopipe
    assign FrameStrobe_O = FrameStrobe;
  end else begin : g_pipe
    logic [MaxFramesPerCol-1:0] pipe_q [STROBE_PIPE];
    logic [MaxFramesPerCol-1:0] pipe_d [STROBE_PIPE];

    always_comb begin
      pipe_d[0] = FrameStrobe;
      for (int unsigned s = 1; s < STROBE_PIPE; s++) pipe_d[s] = pipe_q[s-1];
    end

    always_ff @(posedge UserCLK or negedge resetn) begin
      if (!resetn) begin
        for (int unsigned s = 0; s < STROBE_PIPE; s++) pipe_q[s] <= '0;
      end else begin
        for (int unsigned s = 0; s < STROBE_PIPE; s++) pipe_q[s] <= pipe_d[s];
      end
    end

    assign FrameStrobe_O = pipe_q[STROBE_PIPE-1];
  end

endmodule

// File: tb/tb_s_term_cfg_loopback.sv
// Bench for s_term_cfg_loopback: directed steps followed by random traffic,
// all compared each cycle against a frame/commit-timing reference model.
module tb_s_term_cfg_loopback;

  localparam int W   = 16;
  localparam int MF  = 20;
  localparam int FB  = 32;
  localparam int SP  = 2;
  localparam int NCB = 3 * W;
  localparam int NF  = (NCB + FB - 1) / FB;

  logic            UserCLK = 1'b0;
  logic            resetn;
  logic [4*W-1:0]  S_END;
  logic [W-1:0]    N_BEG;
  logic [FB-1:0]   FrameData;
  logic [MF-1:0]   FrameStrobe;
  logic [MF-1:0]   FrameStrobe_O;
  logic            UserCLKo;
  logic            cfg_busy;

  always #5 UserCLK = ~UserCLK;

  s_term_cfg_loopback #(
    .WIRES(W), .MaxFramesPerCol(MF), .FrameBitsPerRow(FB), .STROBE_PIPE(SP)
  ) dut (
    .UserCLK(UserCLK), .resetn(resetn), .S_END(S_END), .N_BEG(N_BEG),
    .FrameData(FrameData), .FrameStrobe(FrameStrobe), .FrameStrobe_O(FrameStrobe_O),
    .UserCLKo(UserCLKo), .cfg_busy(cfg_busy)
  );

  // Reference model: frames as words, committed config as a flat bit vector,
  // cycles since the last strobe edge, bus history, strobe history.
  logic [FB-1:0]  m_frame [NF];
  logic [NCB-1:0] m_act;
  logic [4*W-1:0] m_prev;
  logic [MF-1:0]  m_hist [SP];
  int             m_since;
  int             n_tests = 0;
  int             n_fail  = 0;

  function automatic logic [NCB-1:0] frames_flat();
    logic [NCB-1:0] v;
    for (int n = 0; n < NCB; n++) v[n] = m_frame[n / FB][n % FB];
    return v;
  endfunction

  function automatic logic [W-1:0] exp_nbeg();
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      int idx;
      idx = int'(m_act[3*i +: 2]) * W + i;
      r[i] = m_act[3*i + 2] ? m_prev[idx] : S_END[idx];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NF; k++) m_frame[k] = '0;
    for (int s = 0; s < SP; s++) m_hist[s] = '0;
    m_act   = '0;
    m_prev  = '0;
    m_since = 2;
  endtask

  // Commit happens on the second edge after the last strobe edge.
  task automatic model_edge();
    if (resetn) begin
      if (m_since == 1) m_act = frames_flat();
      for (int k = 0; k < NF; k++) if (FrameStrobe[k]) m_frame[k] = FrameData;
      if (|FrameStrobe[NF-1:0]) m_since = 0;
      else if (m_since < 2) m_since++;
      m_prev = S_END;
      for (int s = SP - 1; s > 0; s--) m_hist[s] = m_hist[s-1];
      m_hist[0] = FrameStrobe;
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0]  e_n;
    logic [MF-1:0] e_o;
    logic          e_b;
    e_n = exp_nbeg();
    e_o = m_hist[SP-1];
    e_b = (m_since < 2);
    n_tests++;
    assert (N_BEG === e_n) else begin
      n_fail++;
      $error("FAIL %s n_beg observed=%h expected=%h", tag, N_BEG, e_n);
    end
    n_tests++;
    assert (FrameStrobe_O === e_o) else begin
      n_fail++;
      $error("FAIL %s strobe_o observed=%h expected=%h", tag, FrameStrobe_O, e_o);
    end
    n_tests++;
    assert (cfg_busy === e_b) else begin
      n_fail++;
      $error("FAIL %s cfg_busy observed=%b expected=%b", tag, cfg_busy, e_b);
    end
  endtask

  // Drive one cycle's inputs, check outputs, then take the clock edge.
  task automatic cyc(input string tag, input logic [MF-1:0] st,
                     input logic [FB-1:0] fd, input logic [4*W-1:0] se);
    FrameStrobe = st;
    FrameData   = fd;
    S_END       = se;
    #1;
    check_all(tag);
    @(posedge UserCLK);
    model_edge();
    #1;
  endtask

  function automatic logic [4*W-1:0] rnd_bus();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int            busy_cnt;
    logic [4*W-1:0] se;
    logic [MF-1:0]  st;

    // 1: reset, bus0 passes straight through
    resetn = 1'b0;
    FrameStrobe = '0;
    FrameData = '0;
    S_END = {16'h1111, 16'h2222, 16'h3333, 16'hA5A5};
    model_reset();
    #2;
    check_all("reset");
    n_tests++;
    assert (N_BEG === 16'hA5A5) else begin
      n_fail++;
      $error("FAIL reset_bus0 observed=%h expected=%h", N_BEG, 16'hA5A5);
    end
    cyc("reset_hold", '0, '0, S_END);
    cyc("reset_hold", '0, '0, S_END);
    resetn = 1'b1;

    // 2: ch0 sel=2 via one-cycle frame0 write
    busy_cnt = 0;
    cyc("cfg_strobe", 20'h1, 32'h0000_0002, rnd_bus());
    if (cfg_busy) busy_cnt++;
    for (int c = 0; c < 4; c++) begin
      cyc("cfg_idle", '0, $urandom, rnd_bus());
      if (cfg_busy) busy_cnt++;
    end
    n_tests++;
    assert (busy_cnt === 2) else begin
      n_fail++;
      $error("FAIL busy_len observed=%0d expected=%0d", busy_cnt, 2);
    end
    se = rnd_bus();
    S_END = se;
    #1;
    n_tests++;
    assert (N_BEG[0] === se[32]) else begin
      n_fail++;
      $error("FAIL ch0_sel2 observed=%b expected=%b", N_BEG[0], se[32]);
    end

    // 3: ch1 reg_en=1 sel=1 (bits 5..3 = 3'b101), ch0 keeps sel=2
    cyc("regmode_cfg", 20'h1, 32'h0000_002A, rnd_bus());
    for (int c = 0; c < 3; c++) cyc("regmode_wait", '0, '0, rnd_bus());
    se = rnd_bus();
    for (int c = 0; c < 4; c++) begin
      se[17] = ~se[17];
      cyc("regmode_toggle", '0, '0, se);
    end
    // back to combinational for ch1
    cyc("comb_cfg", 20'h1, 32'h0000_000A, se);
    for (int c = 0; c < 3; c++) cyc("comb_wait", '0, '0, se);
    for (int c = 0; c < 4; c++) begin
      se[17] = ~se[17];
      cyc("comb_toggle", '0, '0, se);
    end

    // 4: two-frame burst, ch10 spans frames (sel=3 in frame0, reg_en in frame1)
    cyc("multi_f0", 20'h1, 32'hC000_0000, rnd_bus());
    cyc("multi_f1", 20'h2, 32'h0000_FFF1, rnd_bus());
    for (int c = 0; c < 4; c++) cyc("multi_idle", '0, $urandom, rnd_bus());

    // 5: strobe beyond NF is forwarded only
    cyc("pipe_pulse", 20'h80000, $urandom, rnd_bus());
    for (int c = 0; c < 4; c++) cyc("pipe_idle", '0, $urandom, rnd_bus());

    // 6: reset asserted in the middle of a frame1 write
    cyc("mid_f0", 20'h1, $urandom, rnd_bus());
    FrameStrobe = 20'h2;
    FrameData = $urandom;
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check_all("mid_reset");
    cyc("mid_reset_hold", 20'h2, $urandom, rnd_bus());
    resetn = 1'b1;
    for (int c = 0; c < 4; c++) cyc("post_reset", '0, $urandom, rnd_bus());

    // random traffic with occasional resets
    for (int it = 0; it < 600; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: st = '0;
        4, 5:       st = MF'($urandom) & 20'h00003;
        6:          st = MF'($urandom) & 20'h80000;
        7:          st = 20'h00001;
        default:    st = MF'($urandom);
      endcase
      if ($urandom_range(0, 80) == 0) begin
        FrameStrobe = st;
        S_END = rnd_bus();
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        check_all("rand_reset");
        cyc("rand_reset_hold", st, $urandom, rnd_bus());
        resetn = 1'b1;
      end else begin
        cyc("rand", st, $urandom, rnd_bus());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
